mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port, grant-handshaked memory port (active-low CEN/WEN, byte enables, in-order RVAL response) between NB_REQ requesters. Sits between the cache-refill/test masters and the memory model or macro. It tracks the owner of every outstanding access in an ID FIFO and routes each RVAL/Q back to the requester that issued it. Memory latency is not fixed; responses are only required to return in order.

---
 rtl/mem_arb_pkg.sv | 45 ++++
 rtl/mem_arb_id_fifo.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Holds the request bundle, ID width helper and round-robin pick.
package mem_arb_pkg;

    localparam int MAX_REQ    = 32;
    localparam int REQ_IDX_W  = $clog2(MAX_REQ);
    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 64;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic                  wen;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   be;
    } mem_req_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set request scanning circularly from ptr over nb requesters.
    function automatic int unsigned rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        ptr,
        input int unsigned        nb
    );
        int unsigned idx;
        int unsigned win;
        logic        found;
        win   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = ptr + i;
            if (idx >= nb) idx = idx - nb;
            if ((i < nb) && !found && req[idx[REQ_IDX_W-1:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Owner-ID FIFO: records which requester issued each outstanding access.
// Head is the owner of the oldest access still awaiting its response.
module mem_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             INITN,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_q];

    // Next pointers wrap at DEPTH; count moves only on unbalanced push/pop.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
        if (do_pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    // Pointer and count registers.
    always_ff @(posedge CLK or negedge INITN) begin
        if (!INITN) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // ID storage, written at the tail on push.
    always_ff @(posedge CLK or negedge INITN) begin
        if (!INITN) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one grant-handshaked memory port.
// Responses return in order and are routed by the owner-ID FIFO.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NB_REQ          = 4,
    parameter int ADDR_WIDTH      = MEM_ADDR_W,
    parameter int DATA_WIDTH      = MEM_DATA_W,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                         CLK,
    input  logic                         INITN,
    input  logic [NB_REQ-1:0]            req_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NB_REQ-1:0]            wen_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [NB_REQ*BE_WIDTH-1:0]   be_i,
    output logic [NB_REQ-1:0]            gnt_o,
    output logic [NB_REQ-1:0]            r_valid_o,
    output logic [DATA_WIDTH-1:0]        r_rdata_o,
    output logic                         mem_CEN,
    output logic [ADDR_WIDTH-1:0]        mem_A,
    output logic                         mem_WEN,
    output logic [DATA_WIDTH-1:0]        mem_D,
    output logic [BE_WIDTH-1:0]          mem_BE,
    input  logic                         mem_GNT,
    input  logic [DATA_WIDTH-1:0]        mem_Q,
    input  logic                         mem_RVAL,
    output logic                         resp_err_o
);

    localparam int ID_WIDTH = id_width(NB_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NB_REQ - 1);

    logic [ID_WIDTH-1:0] rr_q, rr_d;
    logic                resp_err_q, resp_err_d;
    logic [ID_WIDTH-1:0] win, sel, head;
    logic                any_req, fifo_full, fifo_empty;
    logic                hs, pop;
    mem_req_t            sel_req;

    assign any_req = |req_i;
    assign win     = ID_WIDTH'(rr_pick(MAX_REQ'(req_i), 32'(rr_q), NB_REQ));

    // fifo_full is the registered count only, keeping RVAL out of CEN.
    assign mem_CEN = ~(any_req & ~fifo_full);
    assign hs      = ~mem_CEN & mem_GNT;
    assign pop     = mem_RVAL & ~fifo_empty;
    assign sel     = mem_CEN ? '0 : win;

    // Winner's request fields onto the memory port.
    always_comb begin
        sel_req.addr  = addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
        sel_req.wen   = wen_i[sel];
        sel_req.wdata = wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
        sel_req.be    = be_i[sel*BE_WIDTH +: BE_WIDTH];
    end

    assign mem_A      = sel_req.addr;
    assign mem_WEN    = sel_req.wen;
    assign mem_D      = sel_req.wdata;
    assign mem_BE     = sel_req.be;
    assign r_rdata_o  = mem_Q;
    assign resp_err_o = resp_err_q;

    // One-hot grant to the winner and response valid to the head owner.
    always_comb begin
        gnt_o     = '0;
        r_valid_o = '0;
        if (hs)  gnt_o[win]      = 1'b1;
        if (pop) r_valid_o[head] = 1'b1;
    end

    // Pointer moves past the winner on a handshake; error is sticky.
    always_comb begin
        rr_d = rr_q;
        if (hs) rr_d = (win == LAST_ID) ? '0 : win + 1'b1;
        resp_err_d = resp_err_q | (mem_RVAL & fifo_empty);
    end

    // Round-robin pointer and response error flag.
    always_ff @(posedge CLK or negedge INITN) begin
        if (!INITN) begin
            rr_q       <= '0;
            resp_err_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            resp_err_q <= resp_err_d;
        end
    end

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_WIDTH)
    ) u_id_fifo (
        .CLK     (CLK),
        .INITN   (INITN),
        .push_i  (hs),
        .pop_i   (pop),
        .data_i  (win),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner cases
// and random traffic against a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int NR   = 4;
    localparam int AW   = 12;
    localparam int DW   = 64;
    localparam int BW   = 8;
    localparam int MAXO = 2;

    logic CLK = 1'b0;
    logic INITN = 1'b1;
    logic [NR-1:0]    req_i, wen_i;
    logic [NR*AW-1:0] addr_i;
    logic [NR*DW-1:0] wdata_i;
    logic [NR*BW-1:0] be_i;
    logic [NR-1:0]    gnt_o, r_valid_o;
    logic [DW-1:0]    r_rdata_o;
    logic             mem_CEN, mem_WEN, mem_GNT, mem_RVAL, resp_err_o;
    logic [AW-1:0]    mem_A;
    logic [DW-1:0]    mem_D, mem_Q;
    logic [BW-1:0]    mem_BE;

    mem_port_arbiter #(
        .NB_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .CLK(CLK), .INITN(INITN),
        .req_i(req_i), .addr_i(addr_i), .wen_i(wen_i),
        .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
        .mem_CEN(mem_CEN), .mem_A(mem_A), .mem_WEN(mem_WEN),
        .mem_D(mem_D), .mem_BE(mem_BE), .mem_GNT(mem_GNT),
        .mem_Q(mem_Q), .mem_RVAL(mem_RVAL), .resp_err_o(resp_err_o)
    );

    always #5 CLK = ~CLK;

    // requester state
    logic          pend [NR];
    logic [AW-1:0] ra   [NR];
    logic          rwen [NR];
    logic [DW-1:0] rd   [NR];
    logic [BW-1:0] rb   [NR];

    // memory model
    logic [DW-1:0] mem [4096];
    typedef struct { int due; logic [DW-1:0] q; } mresp_t;
    mresp_t mq[$];
    int lat;
    int cyc;

    // reference model
    typedef struct { int id; bit rd; logic [DW-1:0] data; } out_t;
    out_t ref_q[$];
    int   ref_rr;
    bit   ref_err;
    bit   exp_hs;
    int   exp_w;

    int npass = 0;
    int ntot  = 0;

    typedef struct {
        logic [3:0]  req;
        bit          mg;
        logic [3:0]  egnt;
        logic [3:0]  erv;
        logic [63:0] edata;
    } vec_t;
    vec_t tv [10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_true(input string nm, input bit ok,
                            input int act, input int req);
        ntot++;
        if (ok) npass++;
        else $display("FAIL %s: got %0d required %0d", nm, act, req);
    endtask

    task automatic clear_ref();
        ref_q.delete();
        mq.delete();
        ref_rr  = 0;
        ref_err = 0;
    endtask

    task automatic pack();
        for (int r = 0; r < NR; r++) begin
            req_i[r]              = pend[r];
            wen_i[r]              = rwen[r];
            addr_i[r*AW +: AW]    = ra[r];
            wdata_i[r*DW +: DW]   = rd[r];
            be_i[r*BW +: BW]      = rb[r];
        end
    endtask

    // Apply inputs, let them settle, compare every output with the model.
    task automatic settle();
        int w, s, idx;
        bit found, any, blocked, ecen;
        logic [3:0] egnt, erv;
        pack();
        #1;
        any     = |req_i;
        blocked = ref_q.size() >= MAXO;
        w = 0;
        found = 0;
        for (int k = 0; k < NR; k++) begin
            idx = (ref_rr + k) % NR;
            if (!found && req_i[idx]) begin
                w = idx;
                found = 1;
            end
        end
        ecen   = !(any && !blocked);
        s      = ecen ? 0 : w;
        exp_hs = !ecen && mem_GNT;
        exp_w  = w;
        egnt   = exp_hs ? 4'(1 << w) : 4'b0;
        erv    = 4'b0;
        if (mem_RVAL && ref_q.size() > 0) erv = 4'(1 << ref_q[0].id);
        chk("mem_CEN", 64'(mem_CEN), 64'(ecen));
        chk("mem_A", 64'(mem_A), 64'(ra[s]));
        chk("mem_WEN", 64'(mem_WEN), 64'(rwen[s]));
        chk("mem_D", mem_D, rd[s]);
        chk("mem_BE", 64'(mem_BE), 64'(rb[s]));
        chk("gnt_o", 64'(gnt_o), 64'(egnt));
        chk("r_valid_o", 64'(r_valid_o), 64'(erv));
        chk("resp_err_o", 64'(resp_err_o), 64'(ref_err));
        if (erv != 0 && ref_q[0].rd)
            chk("r_rdata_o", r_rdata_o, ref_q[0].data);
    endtask

    // Commit this cycle in memory and model, then move to next cycle.
    task automatic advance();
        logic [DW-1:0] q, rdat;
        if (INITN) begin
            rdat = mem[ra[exp_w]];
            if (!mem_CEN && mem_GNT) begin
                q = mem_WEN ? mem[mem_A] : 64'h0;
                if (!mem_WEN)
                    for (int b = 0; b < BW; b++)
                        if (mem_BE[b]) mem[mem_A][8*b +: 8] = mem_D[8*b +: 8];
                mq.push_back('{cyc + lat, q});
            end
            if (mem_RVAL) begin
                if (ref_q.size() > 0) void'(ref_q.pop_front());
                else ref_err = 1;
            end
            if (exp_hs) begin
                ref_q.push_back('{exp_w, rwen[exp_w],
                                  rwen[exp_w] ? rdat : 64'h0});
                ref_rr = (exp_w + 1) % NR;
            end
            for (int r = 0; r < NR; r++) if (gnt_o[r]) pend[r] = 0;
        end
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        mem_RVAL = 1'b0;
        mem_Q    = {$urandom, $urandom};
        if (mq.size() > 0 && mq[0].due == cyc) begin
            mem_RVAL = 1'b1;
            mem_Q    = mq[0].q;
            void'(mq.pop_front());
        end
    endtask

    task automatic do_reset();
        INITN = 1'b0;
        clear_ref();
        mem_GNT  = 1'b1;
        mem_RVAL = 1'b0;
        mem_Q    = '0;
        lat      = 1;
        for (int i = 0; i < 4096; i++)
            mem[i] = {32'(8 * i + 4), 32'(8 * i)};
        for (int r = 0; r < NR; r++) begin
            pend[r] = 0;
            ra[r]   = AW'(r + 3);
            rwen[r] = 1;
            rd[r]   = '0;
            rb[r]   = 8'hFF;
        end
        settle();
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        chk("rst_rvalid", 64'(r_valid_o), 64'h0);
        chk("rst_cen", 64'(mem_CEN), 64'h1);
        chk("rst_err", 64'(resp_err_o), 64'h0);
        advance();
        INITN = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int r = 0; r < NR; r++) pend[r] = 0;
        mem_GNT = 1'b1;
        repeat (n) begin
            settle();
            advance();
        end
    endtask

    initial begin
        int dut_out, ngnt, nrv, seen;

        tv[0] = '{4'b1111, 1, 4'b0001, 4'b0000, 64'h0};
        tv[1] = '{4'b1111, 1, 4'b0010, 4'b0001, 64'h0000001C_00000018};
        tv[2] = '{4'b1111, 1, 4'b0100, 4'b0010, 64'h00000024_00000020};
        tv[3] = '{4'b1111, 1, 4'b1000, 4'b0100, 64'h0000002C_00000028};
        tv[4] = '{4'b1111, 1, 4'b0001, 4'b1000, 64'h00000034_00000030};
        tv[5] = '{4'b0000, 1, 4'b0000, 4'b0001, 64'h0000001C_00000018};
        tv[6] = '{4'b1010, 0, 4'b0000, 4'b0000, 64'h0};
        tv[7] = '{4'b1010, 1, 4'b0010, 4'b0000, 64'h0};
        tv[8] = '{4'b1000, 1, 4'b1000, 4'b0010, 64'h00000024_00000020};
        tv[9] = '{4'b0000, 1, 4'b0000, 4'b1000, 64'h00000034_00000030};

        cyc = 0;
        #1 INITN = 1'b0;
        @(negedge CLK);

        // round-robin and backpressure table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            for (int r = 0; r < NR; r++) pend[r] = tv[i].req[r];
            mem_GNT = tv[i].mg;
            settle();
            chk($sformatf("tv%0d_gnt", i), 64'(gnt_o), 64'(tv[i].egnt));
            chk($sformatf("tv%0d_rv", i), 64'(r_valid_o), 64'(tv[i].erv));
            if (tv[i].erv != 0)
                chk($sformatf("tv%0d_data", i), r_rdata_o, tv[i].edata);
            advance();
        end

        // single read from requester 2, addr 5
        do_reset();
        pend[2] = 1;
        settle();
        chk("single_gnt", 64'(gnt_o), 64'h4);
        advance();
        settle();
        chk("single_rv", 64'(r_valid_o), 64'h4);
        chk("single_data", r_rdata_o, 64'h0000002C_00000028);
        advance();

        // backpressure: rr stays at 0, so requester 1 wins first
        do_reset();
        mem_GNT = 1'b0;
        pend[1] = 1;
        pend[3] = 1;
        repeat (3) begin
            settle();
            chk("bp_gnt", 64'(gnt_o), 64'h0);
            chk("bp_addr", 64'(mem_A), 64'(ra[1]));
            advance();
        end
        mem_GNT = 1'b1;
        settle();
        chk("bp_first", 64'(gnt_o), 64'h2);
        advance();
        settle();
        chk("bp_second", 64'(gnt_o), 64'h8);
        advance();
        drain(3);

        // write then read on requester 3
        do_reset();
        pend[3] = 1;
        rwen[3] = 0;
        ra[3]   = 12'd7;
        rd[3]   = 64'hDEADBEEF_CAFEF00D;
        rb[3]   = 8'h0F;
        settle();
        chk("wr_gnt", 64'(gnt_o), 64'h8);
        chk("wr_wen", 64'(mem_WEN), 64'h0);
        chk("wr_be", 64'(mem_BE), 64'h0F);
        advance();
        pend[3] = 1;
        rwen[3] = 1;
        rb[3]   = 8'hFF;
        settle();
        chk("wr_rv", 64'(r_valid_o), 64'h8);
        chk("rd_gnt", 64'(gnt_o), 64'h8);
        advance();
        pend[3] = 0;
        settle();
        chk("rd_rv", 64'(r_valid_o), 64'h8);
        chk("rd_data", r_rdata_o, 64'h0000003C_CAFEF00D);
        advance();

        // full FIFO with 4-cycle memory
        do_reset();
        lat = 4;
        dut_out = 0;
        ngnt = 0;
        nrv = 0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            for (int r = 0; r < NR; r++) pend[r] = 1;
            settle();
            chk_true("outstanding", dut_out <= MAXO, dut_out, MAXO);
            if (dut_out == MAXO && r_valid_o != 0) begin
                chk("full_pop_stall", 64'(gnt_o), 64'h0);
                seen++;
            end
            ngnt += $countones(gnt_o);
            nrv  += $countones(r_valid_o);
            dut_out += $countones(gnt_o) - $countones(r_valid_o);
            advance();
        end
        for (int r = 0; r < NR; r++) pend[r] = 0;
        for (int c = 0; c < 8; c++) begin
            settle();
            nrv += $countones(r_valid_o);
            advance();
        end
        chk_true("pop_stall_seen", seen > 0, seen, 1);
        chk("no_lost_resp", 64'(nrv), 64'(ngnt));

        // random traffic, two memory latencies
        do_reset();
        foreach (tv[p]) begin
            if (p > 1) break;
            lat = (p == 0) ? 1 : 3;
            for (int c = 0; c < 250; c++) begin
                for (int r = 0; r < NR; r++)
                    if (!pend[r] && $urandom_range(0, 1) == 1) begin
                        pend[r] = 1;
                        ra[r]   = AW'($urandom_range(0, 31));
                        rwen[r] = 1'($urandom_range(0, 1));
                        rd[r]   = {$urandom, $urandom};
                        rb[r]   = 8'($urandom);
                    end
                mem_GNT = ($urandom_range(0, 3) != 0);
                settle();
                advance();
            end
            drain(8);
        end

        // spurious RVAL, then reset mid-burst
        do_reset();
        mem_RVAL = 1'b1;
        settle();
        chk("spur_rv", 64'(r_valid_o), 64'h0);
        advance();
        settle();
        chk("spur_err", 64'(resp_err_o), 64'h1);
        advance();
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < NR; r++) pend[r] = 1;
            settle();
            advance();
        end
        for (int r = 0; r < NR; r++) pend[r] = 1;
        INITN = 1'b0;
        clear_ref();
        settle();
        chk("mid_rst_rv", 64'(r_valid_o), 64'h0);
        chk("mid_rst_err", 64'(resp_err_o), 64'h0);
        chk("mid_rst_gnt", 64'(gnt_o), 64'h1);
        advance();
        for (int r = 0; r < NR; r++) pend[r] = 0;
        INITN = 1'b1;
        settle();
        chk("post_rst_err", 64'(resp_err_o), 64'h0);
        advance();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
